// File: rtl/mem_port_initiator.sv
// Single-outstanding request initiator for a synchronous memory port.
// A request is latched in IDLE, issued for one cycle in ISSUE, read data is
// captured in WAIT, and the response is held in RESP until it is taken.
module mem_port_initiator #(
  parameter  int unsigned ADDR_W = 12,
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 4096,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // memory port
  output logic              mem_en,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_dout,
  // completed-transaction counters
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [STRB_W-1:0] lat_wstrb;

  logic in_range;
  logic strb_any;
  logic req_fire;
  logic rsp_fire;
  logic do_read;
  logic do_write;

  // Decode of the latched request; address compared at 64 bits so DEPTH may exceed 2**ADDR_W.
  always_comb begin
    in_range = (64'(lat_addr) < 64'(DEPTH));
    strb_any = |lat_wstrb;
    do_read  = in_range && !lat_write;
    do_write = in_range && lat_write && strb_any;
    req_fire = req_valid && req_ready;
    rsp_fire = rsp_valid && rsp_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_fire) state_nxt = ISSUE;
      ISSUE:   state_nxt = do_read ? WAIT : RESP;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and memory-port outputs, all zero outside their active state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    mem_wstrb = '0;
    unique case (state)
      IDLE: req_ready = !rst;
      ISSUE: begin
        if (do_read) begin
          mem_en   = 1'b1;
          mem_ren  = 1'b1;
          mem_addr = lat_addr;
        end else if (do_write) begin
          mem_en    = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = lat_addr;
          mem_din   = lat_wdata;
          mem_wstrb = lat_wstrb;
        end
      end
      WAIT: ;
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture on the accepting handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (req_fire) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // Response payload: error flag decided at issue, read data captured in WAIT, cleared once taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        ISSUE: begin
          rsp_rdata <= '0;
          rsp_err   <= !in_range;
        end
        WAIT: rsp_rdata <= mem_dout;
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating completion counters, stepped on the response handshake of non-error transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (rsp_fire && !rsp_err) begin
      if (lat_write) begin
        if (wr_count != '1) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != '1) rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: directed scenarios plus randomized traffic
// checked against a word-array reference of the memory contents.
module tb_mem_port_initiator;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [STRB_W-1:0] req_wstrb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_en, mem_ren, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_dout = '0;
  logic [15:0]       rd_count, wr_count;

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  // memory model behind the DUT port, and the bench's own view of what it should hold
  logic [DATA_W-1:0] mem_arr [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};

  mem_port_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_wstrb(mem_wstrb), .mem_dout(mem_dout),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // one-cycle registered memory
  always @(posedge clk) begin
    if (mem_en && mem_wen && mem_addr < DEPTH)
      for (int i = 0; i < STRB_W; i++)
        if (mem_wstrb[i]) mem_arr[mem_addr[11:0]][8*i +: 8] <= mem_din[8*i +: 8];
    if (mem_en && mem_ren && mem_addr < DEPTH)
      mem_dout <= mem_arr[mem_addr[11:0]];
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"},   rsp_err, 0);
    check({tag, "_mem_ctl"},   {mem_en, mem_ren, mem_wen}, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_din"},   mem_din, 0);
    check({tag, "_mem_wstrb"}, mem_wstrb, 0);
    check({tag, "_rd_count"},  rd_count, 0);
    check({tag, "_wr_count"},  wr_count, 0);
  endtask

  // One complete transaction; quiet skips the per-cycle checks but keeps the model in step.
  task automatic do_txn(input bit w, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input logic [STRB_W-1:0] strb, input int stall, input bit quiet);
    bit inr;
    bit access;
    logic [DATA_W-1:0] exp_data;
    inr    = (int'(addr) < DEPTH);
    access = inr && (!w || strb != 0);
    exp_data = (!w && inr) ? ref_mem[addr[11:0]] : '0;
    if (w && inr)
      for (int i = 0; i < STRB_W; i++)
        if (strb[i]) ref_mem[addr[11:0]][8*i +: 8] = data[8*i +: 8];

    @(negedge clk);
    if (!quiet) check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = data; req_wstrb = strb;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    if (!quiet) begin
      check("issue_rsp_valid", rsp_valid, 0);
      check("issue_req_ready", req_ready, 0);
      check("issue_mem_en",    mem_en, access);
      check("issue_mem_ren",   mem_ren, access && !w);
      check("issue_mem_wen",   mem_wen, access && w);
      check("issue_mem_addr",  mem_addr, access ? addr : '0);
      check("issue_mem_din",   mem_din, (access && w) ? data : '0);
      check("issue_mem_wstrb", mem_wstrb, (access && w) ? strb : '0);
    end
    if (!w && inr) begin
      @(posedge clk); #1;
      if (!quiet) begin
        check("wait_rsp_valid", rsp_valid, 0);
        check("wait_mem_ctl",   {mem_en, mem_ren, mem_wen}, 0);
        check("wait_mem_addr",  mem_addr, 0);
      end
    end
    @(posedge clk); #1;
    if (!quiet) begin
      check("resp_valid",   rsp_valid, 1);
      check("resp_err",     rsp_err, !inr);
      check("resp_rdata",   rsp_rdata, exp_data);
      check("resp_mem_ctl", {mem_en, mem_ren, mem_wen}, 0);
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      if (!quiet) begin
        check("stall_valid",     rsp_valid, 1);
        check("stall_rdata",     rsp_rdata, exp_data);
        check("stall_err",       rsp_err, !inr);
        check("stall_req_ready", req_ready, 0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (inr) begin
      if (w) exp_wr = (exp_wr < 65535) ? exp_wr + 1 : 65535;
      else   exp_rd = (exp_rd < 65535) ? exp_rd + 1 : 65535;
    end
    if (!quiet) begin
      check("done_rsp_valid", rsp_valid, 0);
      check("done_req_ready", req_ready, 1);
      check("done_rd_count",  rd_count, exp_rd);
      check("done_wr_count",  wr_count, exp_wr);
    end
  endtask

  initial begin
    // reset state
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_req_ready", req_ready, 1);

    // write then read back address 5
    do_txn(1'b1, 13'd5, 64'h1122334455667788, 8'hFF, 0, 1'b0);
    do_txn(1'b0, 13'd5, '0, '0, 0, 1'b0);
    check("readback_rdcount", rd_count, 1);
    check("readback_wrcount", wr_count, 1);

    // out-of-range write and read
    do_txn(1'b1, 13'd4096, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 1'b0);
    do_txn(1'b0, 13'd8191, '0, '0, 1, 1'b0);

    // read held in RESP for 5 cycles
    do_txn(1'b0, 13'd5, '0, '0, 5, 1'b0);

    // partial strobes, then zero strobe
    do_txn(1'b1, 13'd4095, 64'hA5A5A5A5A5A5A5A5, 8'h0F, 0, 1'b0);
    do_txn(1'b1, 13'd4095, 64'hFFFFFFFFFFFFFFFF, 8'h00, 2, 1'b0);
    do_txn(1'b0, 13'd4095, '0, '0, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit w;
      logic [ADDR_W-1:0] a;
      logic [STRB_W-1:0] s;
      w = 1'($urandom_range(1, 0));
      a = ($urandom_range(7, 0) == 0) ? ADDR_W'($urandom_range(8191, 4096))
                                      : ADDR_W'($urandom_range(15, 0));
      s = ($urandom_range(5, 0) == 0) ? '0 : STRB_W'($urandom());
      do_txn(w, a, {$urandom(), $urandom()}, s, int'($urandom_range(3, 0)), 1'b0);
    end

    // reset while a read waits for memory data
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 13'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0;
    @(posedge clk); #1;
    check("pre_reset_rdcount_nonzero", rd_count != 0, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_rd = 0;
    exp_wr = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_req_ready", req_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("after_reset_no_rsp", rsp_valid, 0);
      check("after_reset_no_mem", mem_en, 0);
    end

    // drive wr_count to saturation with zero-strobe writes
    for (int n = 0; n < 65535; n++)
      do_txn(1'b1, ADDR_W'(n % DEPTH), '0, '0, 0, 1'b1);
    check("sat_preload_wrcount", wr_count, 16'hFFFF);
    do_txn(1'b1, 13'd7, 64'h0123456789ABCDEF, 8'hFF, 0, 1'b0);
    check("sat_hold_wrcount", wr_count, 16'hFFFF);
    do_txn(1'b0, 13'd7, '0, '0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_initiator.md
MEM_PORT_INITIATOR -- requirements
Module: mem_port_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; STRB_W = DATA_W/8 (derived, not overridable).
REQ-003 SHALL have parameter DEPTH, default 4096, number of valid memory words.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  initiator accepts request.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  word address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port req_wstrb  input  STRB_W  byte enables; bit i covers data[8i+7:8i].
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-014 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err  output  1  address out of range.
REQ-016 SHALL have ports mem_en, mem_ren, mem_wen  output  1 each  memory port controls.
REQ-017 SHALL have ports mem_addr  output  ADDR_W, mem_din  output  DATA_W, mem_wstrb  output  STRB_W.
REQ-018 SHALL have port mem_dout  input  DATA_W  registered memory read data, valid the cycle after a read-enabled edge.
REQ-019 SHALL have ports rd_count, wr_count  output  16 each  completed-transaction counters.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-021 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready; on handshake, latch req_* and go to ISSUE.
REQ-022 In ISSUE, for an in-range read, SHALL drive mem_en=1, mem_ren=1, mem_wen=0, mem_addr=latched addr for exactly one cycle, then go to WAIT.
REQ-023 In ISSUE, for an in-range write with nonzero wstrb, SHALL drive mem_en=1, mem_wen=1, mem_ren=0, mem_addr/mem_din/mem_wstrb = latched values for exactly one cycle, then go to RESP.
REQ-024 Write with wstrb==0 SHALL issue no memory access (mem_en=mem_wen=0), go ISSUE->RESP, rsp_err=0, and SHALL count as a completed write.
REQ-025 Latched addr >= DEPTH SHALL issue no memory access; ISSUE->RESP with rsp_err=1, rsp_rdata=0; SHALL NOT increment either counter.
REQ-026 In WAIT, SHALL register mem_dout into rsp_rdata and go to RESP; memory outputs SHALL be 0.
REQ-027 In RESP, SHALL hold rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1; on that edge go to IDLE.
REQ-028 Latency: read request handshake at edge N -> rsp_valid high from cycle N+3; write/error -> rsp_valid from cycle N+2.
REQ-029 Outside ISSUE, mem_en, mem_ren, mem_wen, mem_wstrb SHALL be 0; mem_addr and mem_din SHALL be 0.
REQ-030 On response handshake, rd_count (read, no error) or wr_count (write, no error) SHALL increment by 1, saturating at 0xFFFF.
REQ-031 rsp_rdata SHALL be 0 for write and error responses.
REQ-032 At most one transaction in flight; new request SHALL NOT be accepted in the cycle the response handshakes.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE; req_ready=1 after deassertion; rsp_valid=0, rsp_rdata=0, rsp_err=0, all mem_* outputs=0, rd_count=wr_count=0.
REQ-034 Reset mid-transaction SHALL drop the pending request with no response and no further memory access.

Verification
REQ-035 Write addr=5, wdata=0x1122334455667788, wstrb=0xFF, rsp_ready=1 -> one-cycle mem_wen pulse with addr 5 and that data; rsp_valid at N+2, rsp_err=0; wr_count=1.
REQ-036 Then read addr=5 against a 1-cycle memory model -> one mem_ren pulse; rsp_rdata=0x1122334455667788 at N+3; rd_count=1.
REQ-037 Write addr=4096, DEPTH=4096 -> no mem_en; rsp_err=1, rsp_rdata=0; counters unchanged.
REQ-038 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; completes on first rsp_ready=1.
REQ-039 Assert rst during WAIT -> all outputs 0 immediately; no rsp_valid afterwards; req_ready=1 after release.
REQ-040 Preload wr_count=0xFFFF via 65535 writes with wstrb=0 -> next write leaves wr_count=0xFFFF.
